// File: rtl/vend_multi_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module  : vend_multi_ctrl_if
// Brief   : Keypad, sensor, restock and status bundle for vend_multi_ctrl.
// Revision: 1.0
// ============================================================================
interface vend_multi_ctrl_if #(
  parameter int N_CH  = 4,
  parameter int CNT_W = 4
);
  localparam int c_sel_w = (N_CH > 1) ? $clog2(N_CH) : 1;

  logic               key_strobe;
  logic [N_CH-1:0]    key_col;
  logic               start;
  logic               cancel;
  logic [N_CH-1:0]    sensor;
  logic               stock_load;
  logic [c_sel_w-1:0] stock_ch;
  logic [CNT_W-1:0]   stock_val;
  logic [N_CH-1:0]    rele;
  logic [CNT_W-1:0]   numero;
  logic [c_sel_w-1:0] sel;
  logic               busy;
  logic               fault;
  logic [N_CH-1:0]    sold_out;

  modport master (
    output key_strobe, key_col, start, cancel, sensor, stock_load, stock_ch, stock_val,
    input  rele, numero, sel, busy, fault, sold_out
  );

  modport slave (
    input  key_strobe, key_col, start, cancel, sensor, stock_load, stock_ch, stock_val,
    output rele, numero, sel, busy, fault, sold_out
  );
endinterface
`default_nettype wire

// File: rtl/vend_multi_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : vend_multi_ctrl
// Brief   : Multi-channel vending controller: keypad/sensor debounce, quantity
//           FSM and dispense watchdog. Define VEND_STOCK_EN for stock limits.
// Revision: 1.0
// ============================================================================
module vend_multi_ctrl #(
  parameter int N_CH    = 4,
  parameter int CNT_W   = 4,
  parameter int KEY_DB  = 255,
  parameter int SENS_DB = 10,
  parameter int TIMEOUT = 50000
) (
  input wire               clk,
  input wire               rst,
  vend_multi_ctrl_if.slave bus
);
  localparam int               c_sel_w   = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int               c_kcnt_w  = $clog2(KEY_DB + 1);
  localparam int               c_scnt_w  = $clog2(SENS_DB + 1);
  localparam int               c_wd_w    = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] c_max_qty = '1;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ARMED    = 2'd1,
    DISPENSE = 2'd2,
    FAULT    = 2'd3
  } state_t;

  state_t             r_state, w_state_nxt;
  logic [CNT_W-1:0]   r_numero, w_numero_nxt;
  logic [c_sel_w-1:0] r_sel, w_sel_nxt;
  logic [c_wd_w-1:0]  r_wdog, w_wdog_nxt;
  logic [N_CH-1:0]    r_rele, w_rele_nxt;

  // ---------------- keypad debounce ----------------
  logic [N_CH-1:0]     r_key_prev;
  logic [c_kcnt_w-1:0] r_key_cnt, w_key_cnt_nxt;
  logic                r_key_ready;
  logic [N_CH-1:0]     w_key_hot;
  logic                w_key_valid, w_key_acc, w_key_take;
  logic [c_sel_w-1:0]  w_key_idx;

  assign w_key_hot   = ~bus.key_col;
  assign w_key_valid = (w_key_hot != '0) && ((w_key_hot & (w_key_hot - N_CH'(1))) == '0);

  always_comb begin
    w_key_idx = '0;
    for (int k = 0; k < N_CH; k++)
      if (w_key_hot[k]) w_key_idx = c_sel_w'(k);
  end

  always_comb begin
    w_key_cnt_nxt = r_key_cnt;
    if (bus.key_col != r_key_prev)
      w_key_cnt_nxt = c_kcnt_w'(1);
    else if (r_key_cnt != c_kcnt_w'(KEY_DB))
      w_key_cnt_nxt = r_key_cnt + c_kcnt_w'(1);
  end

  assign w_key_acc = bus.key_strobe && w_key_valid && r_key_ready &&
                     (w_key_cnt_nxt == c_kcnt_w'(KEY_DB));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_key_prev  <= '1;
      r_key_cnt   <= '0;
      r_key_ready <= 1'b1;
    end else if (bus.key_strobe) begin
      r_key_prev <= bus.key_col;
      r_key_cnt  <= w_key_cnt_nxt;
      // one accept per press: re-armed only by an idle sample
      if (!w_key_valid)   r_key_ready <= 1'b1;
      else if (w_key_acc) r_key_ready <= 1'b0;
    end
  end

  // ---------------- sensor debounce ----------------
  logic [N_CH-1:0] w_sens_evt;
  logic            w_evt_sel;

  generate
    for (genvar k = 0; k < N_CH; k++) begin : g_sens
      logic [c_scnt_w-1:0] r_cnt;
      logic                r_stab;
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_cnt  <= '0;
          r_stab <= 1'b1;
        end else if (bus.sensor[k] != r_stab) begin
          if (r_cnt == c_scnt_w'(SENS_DB - 1)) begin
            r_cnt  <= '0;
            r_stab <= ~r_stab;
          end else begin
            r_cnt <= r_cnt + c_scnt_w'(1);
          end
        end else begin
          r_cnt <= '0;
        end
      end
      assign w_sens_evt[k] = r_stab && !bus.sensor[k] && (r_cnt == c_scnt_w'(SENS_DB - 1));
    end
  endgenerate

  assign w_evt_sel = w_sens_evt[r_sel];

  // ---------------- stock tracking ----------------
  logic w_key_soldout, w_inc_ok, w_stock_dec;
  assign w_stock_dec = (r_state == DISPENSE) && w_evt_sel;

`ifdef VEND_STOCK_EN
  logic [CNT_W-1:0] r_stock     [N_CH];
  logic [CNT_W-1:0] w_stock_nxt [N_CH];
  logic [N_CH-1:0]  r_sold_out;

  always_comb begin
    for (int k = 0; k < N_CH; k++) begin
      w_stock_nxt[k] = r_stock[k];
      if (bus.stock_load && bus.stock_ch == c_sel_w'(k))
        w_stock_nxt[k] = bus.stock_val;
      else if (w_stock_dec && r_sel == c_sel_w'(k) && r_stock[k] != '0)
        w_stock_nxt[k] = r_stock[k] - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < N_CH; k++) r_stock[k] <= '0;
      r_sold_out <= '0;
    end else begin
      for (int k = 0; k < N_CH; k++) begin
        r_stock[k]    <= w_stock_nxt[k];
        r_sold_out[k] <= (w_stock_nxt[k] == '0);
      end
    end
  end

  assign w_key_soldout = (r_stock[w_key_idx] == '0);
  assign w_inc_ok      = (r_numero != c_max_qty) && (r_numero < r_stock[r_sel]);
  assign bus.sold_out  = r_sold_out;
`else
  logic w_unused_stock;
  assign w_unused_stock = ^{bus.stock_load, bus.stock_ch, bus.stock_val, w_stock_dec};
  assign w_key_soldout  = 1'b0;
  assign w_inc_ok       = (r_numero != c_max_qty);
  assign bus.sold_out   = '0;
`endif

  assign w_key_take = w_key_acc && !w_key_soldout;

  // ---------------- control FSM ----------------
  always_comb begin
    w_state_nxt  = r_state;
    w_numero_nxt = r_numero;
    w_sel_nxt    = r_sel;
    w_wdog_nxt   = r_wdog;
    case (r_state)
      IDLE: begin
        if (w_key_take) begin
          w_sel_nxt    = w_key_idx;
          w_numero_nxt = CNT_W'(1);
          w_state_nxt  = ARMED;
        end
      end
      ARMED: begin
        if (bus.cancel) begin
          w_numero_nxt = '0;
          w_state_nxt  = IDLE;
        end else if (bus.start) begin
          w_wdog_nxt  = '0;
          w_state_nxt = DISPENSE;
        end else if (w_key_take) begin
          if (w_key_idx == r_sel) begin
            if (w_inc_ok) w_numero_nxt = r_numero + CNT_W'(1);
          end else begin
            w_sel_nxt    = w_key_idx;
            w_numero_nxt = CNT_W'(1);
          end
        end
      end
      DISPENSE: begin
        if (bus.cancel) begin
          w_numero_nxt = '0;
          w_state_nxt  = IDLE;
        end else if (w_evt_sel) begin
          w_numero_nxt = r_numero - CNT_W'(1);
          w_wdog_nxt   = '0;
          if (r_numero == CNT_W'(1)) w_state_nxt = IDLE;
        end else if (r_wdog == c_wd_w'(TIMEOUT - 1)) begin
          w_state_nxt = FAULT;
        end else begin
          w_wdog_nxt = r_wdog + c_wd_w'(1);
        end
      end
      FAULT: begin
        if (bus.cancel) begin
          w_numero_nxt = '0;
          w_state_nxt  = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
    // relay follows the next state so it is already registered on DISPENSE entry
    w_rele_nxt = '0;
    if (w_state_nxt == DISPENSE) w_rele_nxt[w_sel_nxt] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      r_numero <= '0;
      r_sel    <= '0;
      r_wdog   <= '0;
      r_rele   <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_numero <= w_numero_nxt;
      r_sel    <= w_sel_nxt;
      r_wdog   <= w_wdog_nxt;
      r_rele   <= w_rele_nxt;
    end
  end

  assign bus.rele   = r_rele;
  assign bus.numero = r_numero;
  assign bus.sel    = r_sel;
  assign bus.busy   = (r_state == DISPENSE);
  assign bus.fault  = (r_state == FAULT);
endmodule
`default_nettype wire

// File: tb/tb_vend_multi_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_vend_multi_ctrl
// Brief   : Directed and randomized checks of vend_multi_ctrl against a
//           transaction-level model of the vending rules.
// Revision: 1.0
// ============================================================================
module tb_vend_multi_ctrl;
  localparam int N_CH    = 4;
  localparam int CNT_W   = 4;
  localparam int KEY_DB  = 255;
  localparam int SENS_DB = 10;
  localparam int TIMEOUT = 200;
  localparam int MAX_QTY = (1 << CNT_W) - 1;
  localparam int SW      = $clog2(N_CH);

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  vend_multi_ctrl_if #(.N_CH(N_CH), .CNT_W(CNT_W)) bus ();

  vend_multi_ctrl #(
    .N_CH(N_CH), .CNT_W(CNT_W), .KEY_DB(KEY_DB), .SENS_DB(SENS_DB), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  task automatic idle_inputs();
    bus.key_strobe = 1'b0;
    bus.key_col    = '1;
    bus.start      = 1'b0;
    bus.cancel     = 1'b0;
    bus.sensor     = '1;
    bus.stock_load = 1'b0;
    bus.stock_ch   = '0;
    bus.stock_val  = '0;
  endtask

  task automatic load_stock(input int ch, input int val);
    @(negedge clk);
    bus.stock_load = 1'b1;
    bus.stock_ch   = SW'(ch);
    bus.stock_val  = CNT_W'(val);
    @(negedge clk);
    bus.stock_load = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
`ifdef VEND_STOCK_EN
    for (int k = 0; k < N_CH; k++) load_stock(k, MAX_QTY);
`endif
  endtask

  // KEY_DB strobed samples of pat (optional unstrobed gaps), then one idle sample
  task automatic press_pat(input logic [N_CH-1:0] pat, input bit gaps, input bit start_at_acc);
    for (int i = 0; i < KEY_DB; i++) begin
      if (gaps && $urandom_range(0, 7) == 0) begin
        @(negedge clk);
        bus.key_strobe = 1'b0;
        bus.key_col    = N_CH'($urandom);
      end
      @(negedge clk);
      bus.key_strobe = 1'b1;
      bus.key_col    = pat;
      bus.start      = start_at_acc && (i == KEY_DB - 1);
    end
    @(negedge clk);
    bus.start   = 1'b0;
    bus.key_col = '1;
    @(negedge clk);
    bus.key_strobe = 1'b0;
  endtask

  task automatic press_key(input int k);
    press_pat(~(N_CH'(1) << k), 1'b0, 1'b0);
  endtask

  task automatic sens_pulse(input int ch, input int len);
    @(negedge clk);
    bus.sensor[ch] = 1'b0;
    repeat (len) @(negedge clk);
    bus.sensor[ch] = 1'b1;
    repeat (SENS_DB + 2) @(negedge clk);
  endtask

  task automatic pulse_start();
    @(negedge clk); bus.start = 1'b1;
    @(negedge clk); bus.start = 1'b0;
  endtask

  task automatic pulse_cancel();
    @(negedge clk); bus.cancel = 1'b1;
    @(negedge clk); bus.cancel = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    @(negedge clk);
    n_tests++; if (bus.numero !== '0) begin n_fail++; $display("FAIL reset_numero: got %0d want 0", bus.numero); end
    n_tests++; if (bus.rele !== '0) begin n_fail++; $display("FAIL reset_rele: got %b want 0", bus.rele); end
    n_tests++; if (bus.sel !== '0) begin n_fail++; $display("FAIL reset_sel: got %0d want 0", bus.sel); end
    n_tests++; if ({bus.busy, bus.fault} !== 2'b00) begin n_fail++; $display("FAIL reset_status: busy/fault got %b want 00", {bus.busy, bus.fault}); end
    n_tests++; if (bus.sold_out !== '0) begin n_fail++; $display("FAIL reset_sold_out: got %b want 0", bus.sold_out); end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    do_reset();
    press_key(2);
    n_tests++; if (bus.sel !== SW'(2) || bus.numero !== CNT_W'(1)) begin n_fail++; $display("FAIL basic_first_key: sel %0d numero %0d want 2 1", bus.sel, bus.numero); end
    press_key(2);
    n_tests++; if (bus.numero !== CNT_W'(2)) begin n_fail++; $display("FAIL basic_second_key: got %0d want 2", bus.numero); end
    pulse_start();
    n_tests++; if (bus.rele !== 4'b0100 || bus.busy !== 1'b1) begin n_fail++; $display("FAIL basic_dispense: rele %b busy %b want 0100 1", bus.rele, bus.busy); end
    sens_pulse(2, SENS_DB);
    n_tests++; if (bus.numero !== CNT_W'(1) || bus.rele !== 4'b0100) begin n_fail++; $display("FAIL basic_event1: numero %0d rele %b want 1 0100", bus.numero, bus.rele); end
    sens_pulse(2, SENS_DB + 3);
    n_tests++; if (bus.numero !== '0 || bus.rele !== '0 || bus.busy !== 1'b0) begin n_fail++; $display("FAIL basic_event2: numero %0d rele %b busy %b want 0 0000 0", bus.numero, bus.rele, bus.busy); end
  endtask

  task automatic test_glitch();
    do_reset();
    press_key(1);
    press_key(1);
    pulse_start();
    sens_pulse(1, SENS_DB - 1);
    n_tests++; if (bus.numero !== CNT_W'(2)) begin n_fail++; $display("FAIL glitch_short: numero got %0d want 2", bus.numero); end
    sens_pulse(0, SENS_DB + 2);
    n_tests++; if (bus.numero !== CNT_W'(2)) begin n_fail++; $display("FAIL glitch_other_ch: numero got %0d want 2", bus.numero); end
    sens_pulse(1, SENS_DB);
    n_tests++; if (bus.numero !== CNT_W'(1) || bus.busy !== 1'b1) begin n_fail++; $display("FAIL glitch_full: numero %0d busy %b want 1 1", bus.numero, bus.busy); end
    @(negedge clk); bus.cancel = 1'b1;
    @(negedge clk); bus.cancel = 1'b0;
    n_tests++; if (bus.numero !== '0 || bus.rele !== '0 || bus.busy !== 1'b0) begin n_fail++; $display("FAIL dispense_cancel: numero %0d rele %b busy %b want 0 0000 0", bus.numero, bus.rele, bus.busy); end
  endtask

  task automatic test_timeout();
    do_reset();
    press_key(3);
    @(negedge clk); bus.start = 1'b1;
    @(posedge clk); #1 bus.start = 1'b0;
    repeat (TIMEOUT - 1) @(posedge clk);
    #1;
    n_tests++; if (bus.fault !== 1'b0 || bus.busy !== 1'b1) begin n_fail++; $display("FAIL timeout_early: fault %b busy %b want 0 1", bus.fault, bus.busy); end
    @(posedge clk); #1;
    n_tests++; if (bus.fault !== 1'b1 || bus.rele !== '0 || bus.numero !== CNT_W'(1)) begin n_fail++; $display("FAIL timeout_fault: fault %b rele %b numero %0d want 1 0000 1", bus.fault, bus.rele, bus.numero); end
    pulse_cancel();
    n_tests++; if (bus.fault !== 1'b0 || bus.numero !== '0) begin n_fail++; $display("FAIL fault_cancel: fault %b numero %0d want 0 0", bus.fault, bus.numero); end
  endtask

  task automatic test_start_cancel();
    do_reset();
    press_key(1);
    @(negedge clk); bus.start = 1'b1; bus.cancel = 1'b1;
    @(negedge clk); bus.start = 1'b0; bus.cancel = 1'b0;
    n_tests++; if (bus.numero !== '0 || bus.busy !== 1'b0 || bus.rele !== '0) begin n_fail++; $display("FAIL start_cancel: numero %0d busy %b rele %b want 0 0 0000", bus.numero, bus.busy, bus.rele); end
    press_key(1);
    press_pat(~(N_CH'(1) << 1), 1'b0, 1'b1);
    n_tests++; if (bus.numero !== CNT_W'(1) || bus.busy !== 1'b1 || bus.rele !== 4'b0010) begin n_fail++; $display("FAIL key_with_start: numero %0d busy %b rele %b want 1 1 0010", bus.numero, bus.busy, bus.rele); end
  endtask

  task automatic test_saturate();
    do_reset();
    for (int i = 0; i < MAX_QTY + 2; i++) press_key(0);
    n_tests++; if (bus.numero !== CNT_W'(MAX_QTY)) begin n_fail++; $display("FAIL saturate: numero got %0d want %0d", bus.numero, MAX_QTY); end
    press_key(3);
    n_tests++; if (bus.numero !== CNT_W'(1) || bus.sel !== SW'(3)) begin n_fail++; $display("FAIL key_change: numero %0d sel %0d want 1 3", bus.numero, bus.sel); end
  endtask

  task automatic test_async_reset();
    do_reset();
    press_key(2);
    press_key(2);
    pulse_start();
    @(posedge clk); #3 rst = 1'b1;
    #1;
    n_tests++; if (bus.rele !== '0 || bus.numero !== '0 || bus.busy !== 1'b0) begin n_fail++; $display("FAIL async_reset: rele %b numero %0d busy %b want 0000 0 0", bus.rele, bus.numero, bus.busy); end
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_random();
    int m_state, m_num, m_sel, nonev, act, k, a, b;
    int m_stock [N_CH];
    logic [N_CH-1:0] exp_rele;
    do_reset();
    m_state = 0; m_num = 0; m_sel = 0; nonev = 0;
    for (int i = 0; i < N_CH; i++) m_stock[i] = MAX_QTY;
    for (int n = 0; n < 60; n++) begin
      act = $urandom_range(0, 9);
      if (m_state == 2) begin
        if (nonev >= 5 || act < 6) begin
          sens_pulse(m_sel, SENS_DB + $urandom_range(0, 3));
          m_num--; nonev = 0;
          if (m_stock[m_sel] > 0) m_stock[m_sel]--;
          if (m_num == 0) m_state = 0;
        end else if (act < 8) begin
          sens_pulse(m_sel, $urandom_range(1, SENS_DB - 1)); nonev++;
        end else if (act < 9) begin
          sens_pulse((m_sel + 1 + $urandom_range(0, N_CH - 2)) % N_CH, SENS_DB + 1); nonev++;
        end else begin
          pulse_cancel(); m_state = 0; m_num = 0;
        end
      end else begin
        if (act < 6) begin
          k = (m_state == 1 && act < 3) ? m_sel : $urandom_range(0, N_CH - 1);
          press_pat(~(N_CH'(1) << k), $urandom_range(0, 1) == 1, 1'b0);
`ifdef VEND_STOCK_EN
          if (m_stock[k] != 0) begin
`else
          begin
`endif
            if (m_state == 0 || k != m_sel) begin m_state = 1; m_sel = k; m_num = 1; end
`ifdef VEND_STOCK_EN
            else if (m_num < MAX_QTY && m_num < m_stock[m_sel]) m_num++;
`else
            else if (m_num < MAX_QTY) m_num++;
`endif
          end
        end else if (act < 7) begin
          a = $urandom_range(0, N_CH - 1);
          b = (a + 1 + $urandom_range(0, N_CH - 2)) % N_CH;
          press_pat(~((N_CH'(1) << a) | (N_CH'(1) << b)), 1'b1, 1'b0);
        end else if (act < 9) begin
          pulse_start();
          if (m_state == 1) begin m_state = 2; nonev = 0; end
        end else begin
          pulse_cancel(); m_state = 0; m_num = 0;
        end
      end
      exp_rele = (m_state == 2) ? (N_CH'(1) << m_sel) : '0;
      n_tests++; if (bus.numero !== CNT_W'(m_num)) begin n_fail++; $display("FAIL rand_numero step %0d: got %0d want %0d", n, bus.numero, m_num); end
      n_tests++; if (bus.rele !== exp_rele || bus.busy !== (m_state == 2)) begin n_fail++; $display("FAIL rand_rele step %0d: rele %b busy %b want %b %b", n, bus.rele, bus.busy, exp_rele, m_state == 2); end
      if (m_state != 0) begin
        n_tests++; if (bus.sel !== SW'(m_sel)) begin n_fail++; $display("FAIL rand_sel step %0d: got %0d want %0d", n, bus.sel, m_sel); end
      end
    end
  endtask

`ifdef VEND_STOCK_EN
  task automatic test_stock();
    do_reset();
    load_stock(1, 1);
    press_key(1);
    press_key(1);
    n_tests++; if (bus.numero !== CNT_W'(1)) begin n_fail++; $display("FAIL stock_cap: numero got %0d want 1", bus.numero); end
    pulse_start();
    sens_pulse(1, SENS_DB);
    n_tests++; if (bus.sold_out[1] !== 1'b1 || bus.busy !== 1'b0) begin n_fail++; $display("FAIL stock_sold_out: sold_out %b busy %b want x1x 0", bus.sold_out, bus.busy); end
    press_key(1);
    n_tests++; if (bus.numero !== '0) begin n_fail++; $display("FAIL stock_reject: numero got %0d want 0", bus.numero); end
    pulse_start();
    n_tests++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL stock_reject_start: busy got %b want 0", bus.busy); end
  endtask
`endif

  initial begin
    idle_inputs();
    test_reset();
    test_basic();
    test_glitch();
    test_timeout();
    test_start_cancel();
    test_saturate();
    test_async_reset();
    test_random();
`ifdef VEND_STOCK_EN
    test_stock();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
